m20k_bram_tdp_cfg: RTL and testbench
====================================

// Module: m20k_bram_tdp_cfg
// PURPOSE
//  Parametrised true-dual-port model of one M20K block over a fixed 128x160 physical
//  bit-cell array. Provides a selectable logical aspect ratio, an optional output
//  register stage, per-port read-valid strobes, a selectable read-during-write mode and
//  write-collision detection. It is the base memory primitive for the transpose datapath.
// PARAMETERS
//  DATA_WIDTH   8  logical word width W; legal values 1,2,4,5,8,10,20,40 (must divide 160)
//  OUT_REG      0  0: read latency 1 cycle; 1: extra output register, latency 2 cycles
//  RDW_MODE     0  same-port read-during-write: 0 = old data, 1 = new (write) data
//  (derived) WPR = 160/W words per row; DEPTH = 128*WPR; ADDR_WIDTH = clog2(DEPTH)
// PORTS
//  clk          in   1           single clock, all logic on posedge
//  rst          in   1           asynchronous, active-high reset
//  addr_a       in   ADDR_WIDTH  port A word address
//  data_in_a    in   W           port A write data
//  wen_a        in   1           port A write enable
//  ren_a        in   1           port A read enable
//  data_out_a   out  W           port A read data
//  rd_valid_a   out  1           port A read-data-valid strobe
//  addr_b, data_in_b, wen_b, ren_b, data_out_b, rd_valid_b: same as port A, for port B
//  collision    out  1           1-cycle pulse: both ports wrote the same address
// BEHAVIOUR
//  - Mapping: row = addr / WPR; col_start = (addr % WPR) * W.
//    Word bit i is held in cell[row][col_start+i].
//  - Out of range: an address >= DEPTH is ignored on write. On read it returns all zeros
//    and still asserts rd_valid.
//  - Reset (async): data_out_a/b = 0, rd_valid_a/b = 0, collision = 0, and all pipeline
//    registers are cleared. The cell array is not reset; it initialises to 0 at time zero.
//  - Reset mid-operation: any read in flight is dropped and no rd_valid is produced for it.
//    Writes presented during the reset are not performed.
//  - Write: performed at the posedge when wen is 1. It is visible to any read issued on a
//    later cycle.
//  - Read, OUT_REG=0: ren sampled at edge N -> data_out and rd_valid=1 at edge N.
//    rd_valid is 1 for exactly one cycle per accepted read.
//  - Read, OUT_REG=1: ren sampled at edge N -> data_out and rd_valid=1 at edge N+1.
//    Reads may be issued every cycle; the pipeline is fully throughput-1.
//  - data_out holds its last value while no read completes. It is never cleared except
//    by reset.
//  - Same-port read-during-write (ren & wen, same cycle):
//    RDW_MODE=0 returns the pre-write word; RDW_MODE=1 returns data_in.
//  - Cross-port read-during-write to the same address always returns the old data.
//  - Collision: wen_a & wen_b with equal in-range addresses -> port A data is stored and
//    collision=1 on the following cycle.
//    Different addresses in the same physical row both write. They do not collide.
//  - No state machine is used beyond the valid pipeline. There is no backpressure; the
//    consumer must accept data in the cycle rd_valid is asserted.
// TESTING
//  T1 W=40, OUT_REG=0:
//     write A addr 5 = 0x123456789A, then ren_b addr 5 -> data_out_b = 0x123456789A,
//     rd_valid_b high for one cycle at the read edge.
//  T2 W=8:
//     write addr 21 = 0xC3 -> cell row 1 cols 8..15 = 0xC3; read addr 20 -> 0x00;
//     read addr 21 -> 0xC3.
//  T3 W=8, both ports write addr 3 (A=0x11, B=0x22) ->
//     collision pulses for 1 cycle; read addr 3 -> 0x11.
//  T4 W=8, addr 7 holds 0xAA; ren_a & wen_a addr 7 with data 0x55:
//     RDW_MODE=0 -> data_out_a = 0xAA, next read -> 0x55.
//     RDW_MODE=1 -> data_out_a = 0x55.
//  T5 OUT_REG=1, back-to-back reads of addrs 0..3 ->
//     4 consecutive rd_valid cycles, each 2 cycles after its ren.
//     Then assert rst one cycle after a ren -> no rd_valid, data_out = 0.
//  T6 W=8 (DEPTH=2560):
//     write addr 3000 = 0xFF -> no cell changes; read addr 3000 -> 0x00 with rd_valid=1.

Source files
------------

// File: rtl/m20k_bram_tdp_cfg_if.sv
// m20k_bram_tdp_cfg_if: dual-port bus of the M20K model, one address/data/enable set per port
// plus the read-valid strobes and the write-collision pulse.
interface m20k_bram_tdp_cfg_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 12
);
   logic [ADDR_WIDTH-1:0] addr_a, addr_b;
   logic [DATA_WIDTH-1:0] data_in_a, data_in_b, data_out_a, data_out_b;
   logic wen_a, wen_b, ren_a, ren_b, rd_valid_a, rd_valid_b, collision;
   modport master (
      output addr_a, data_in_a, wen_a, ren_a, addr_b, data_in_b, wen_b, ren_b,
      input  data_out_a, rd_valid_a, data_out_b, rd_valid_b, collision
   );
   modport slave (
      input  addr_a, data_in_a, wen_a, ren_a, addr_b, data_in_b, wen_b, ren_b,
      output data_out_a, rd_valid_a, data_out_b, rd_valid_b, collision
   );
endinterface

// File: rtl/m20k_bram_tdp_cfg.sv
// m20k_bram_tdp_cfg: true-dual-port M20K model over a 128x160 cell array with selectable
// aspect ratio, optional output register, read-during-write mode and collision detection.
module m20k_bram_tdp_cfg #(
   parameter int DATA_WIDTH = 8,
   parameter int OUT_REG    = 0,
   parameter int RDW_MODE   = 0
) (
   input logic clk,
   input logic rst,
   m20k_bram_tdp_cfg_if.slave bus
);
   localparam int WPR   = 160 / DATA_WIDTH;
   localparam int DEPTH = 128 * WPR;
   localparam int AW    = $clog2(DEPTH);
   logic [159:0] mem [128];
   logic [AW-1:0] addr [2];
   logic [DATA_WIDTH-1:0] din [2];
   logic wen [2];
   logic ren [2];
   assign addr[0] = bus.addr_a;
   assign addr[1] = bus.addr_b;
   assign din[0]  = bus.data_in_a;
   assign din[1]  = bus.data_in_b;
   assign wen[0]  = bus.wen_a;
   assign wen[1]  = bus.wen_b;
   assign ren[0]  = bus.ren_a;
   assign ren[1]  = bus.ren_b;
   for (genvar p = 0; p < 2; p++) begin : g_port
      logic in_rng, v, dv;
      logic [6:0] row;
      logic [7:0] col;
      logic [DATA_WIDTH-1:0] rd_data, q, dout;
      assign in_rng = 32'(addr[p]) < DEPTH;
      assign row = 7'(addr[p] / AW'(WPR));
      assign col = 8'(32'(addr[p] % AW'(WPR)) * DATA_WIDTH);
      // Cross-port reads see the array before this edge's writes, so only own-port RDW can forward.
      assign rd_data = !in_rng ? '0 :
                       (RDW_MODE != 0 && wen[p]) ? din[p] : mem[row][col +: DATA_WIDTH];
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            v <= 1'b0;
            q <= '0;
         end else begin
            v <= ren[p];
            if (ren[p]) q <= rd_data;
         end
      if (OUT_REG != 0) begin : g_oreg
         always_ff @(posedge clk or posedge rst)
            if (rst) begin
               dv   <= 1'b0;
               dout <= '0;
            end else begin
               dv <= v;
               if (v) dout <= q;
            end
      end else begin : g_noreg
         assign dv   = v;
         assign dout = q;
      end
   end
   // Array is never cleared; reset only blocks writes. Port A is applied last so it wins a tie.
   always_ff @(posedge clk or posedge rst)
      if (!rst) begin
         if (wen[1] && g_port[1].in_rng) mem[g_port[1].row][g_port[1].col +: DATA_WIDTH] <= din[1];
         if (wen[0] && g_port[0].in_rng) mem[g_port[0].row][g_port[0].col +: DATA_WIDTH] <= din[0];
      end
   always_ff @(posedge clk or posedge rst)
      if (rst) bus.collision <= 1'b0;
      else bus.collision <= wen[0] && wen[1] && g_port[0].in_rng && g_port[1].in_rng && addr[0] == addr[1];
   assign bus.data_out_a = g_port[0].dout;
   assign bus.data_out_b = g_port[1].dout;
   assign bus.rd_valid_a = g_port[0].dv;
   assign bus.rd_valid_b = g_port[1].dv;
endmodule

// File: tb/tb_m20k_bram_tdp_cfg.sv
// tb_m20k_bram_tdp_cfg: scoreboard bench; three W=8 variants share one stimulus stream,
// plus a W=40 instance. Expected reads are queued per port and popped on rd_valid.
module tb_m20k_bram_tdp_cfg;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   int cyc = 0, checks = 0, passed = 0, coll_due = -1;
   always @(posedge clk) cyc <= cyc + 1;
   typedef struct {logic [39:0] d; int due;} exp_t;
   exp_t q [8][$];
   logic [11:0] addr_a, addr_b;
   logic [7:0] din_a, din_b;
   logic wen_a, wen_b, ren_a, ren_b;
   logic [8:0] w_addr_a, w_addr_b;
   logic [39:0] w_din_a, w_din_b;
   logic w_wen_a, w_wen_b, w_ren_a, w_ren_b;

   function automatic void check(input string n, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, act, exp);
   endfunction

   function automatic void mon(input int i, input logic v, input logic [39:0] d);
      exp_t e;
      if (v !== 1'b1) return;
      if (q[i].size() == 0) begin
         check($sformatf("spurious rd_valid q%0d", i), {39'b0, v}, 40'b0);
         return;
      end
      e = q[i].pop_front();
      check($sformatf("read data q%0d", i), d, e.d);
      check($sformatf("read latency q%0d", i), 40'(cyc), 40'(e.due));
   endfunction

   m20k_bram_tdp_cfg_if #(.DATA_WIDTH(8), .ADDR_WIDTH(12)) b8 [3] ();
   m20k_bram_tdp_cfg_if #(.DATA_WIDTH(40), .ADDR_WIDTH(9)) b40 ();

   // k0: OUT_REG=0 RDW=0, k1: OUT_REG=0 RDW=1, k2: OUT_REG=1 RDW=0
   for (genvar k = 0; k < 3; k++) begin : g_dut
      logic [18:0] outs;
      assign b8[k].addr_a = addr_a;
      assign b8[k].addr_b = addr_b;
      assign b8[k].data_in_a = din_a;
      assign b8[k].data_in_b = din_b;
      assign b8[k].wen_a = wen_a;
      assign b8[k].wen_b = wen_b;
      assign b8[k].ren_a = ren_a;
      assign b8[k].ren_b = ren_b;
      assign outs = {b8[k].data_out_a, b8[k].data_out_b, b8[k].rd_valid_a, b8[k].rd_valid_b, b8[k].collision};
      m20k_bram_tdp_cfg #(.DATA_WIDTH(8), .OUT_REG(k == 2 ? 1 : 0), .RDW_MODE(k == 1 ? 1 : 0)) dut (
         .clk(clk), .rst(rst), .bus(b8[k])
      );
      initial forever begin
         @(posedge clk);
         #1;
         mon(2 * k, b8[k].rd_valid_a, {32'b0, b8[k].data_out_a});
         mon(2 * k + 1, b8[k].rd_valid_b, {32'b0, b8[k].data_out_b});
         check($sformatf("collision k%0d", k), {39'b0, b8[k].collision}, {39'b0, cyc == coll_due});
      end
   end

   assign b40.addr_a = w_addr_a;
   assign b40.addr_b = w_addr_b;
   assign b40.data_in_a = w_din_a;
   assign b40.data_in_b = w_din_b;
   assign b40.wen_a = w_wen_a;
   assign b40.wen_b = w_wen_b;
   assign b40.ren_a = w_ren_a;
   assign b40.ren_b = w_ren_b;
   m20k_bram_tdp_cfg #(.DATA_WIDTH(40), .OUT_REG(0), .RDW_MODE(0)) dut40 (
      .clk(clk), .rst(rst), .bus(b40)
   );
   initial forever begin
      @(posedge clk);
      #1;
      mon(6, b40.rd_valid_a, b40.data_out_a);
      mon(7, b40.rd_valid_b, b40.data_out_b);
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle();
      {wen_a, wen_b, ren_a, ren_b} = '0;
      {w_wen_a, w_wen_b, w_ren_a, w_ren_b} = '0;
   endtask

   // e0 is the answer for RDW=0 variants, e1 for RDW=1; drop2 skips the OUT_REG=1 instance.
   task automatic push8(input int p, input logic [7:0] e0, input logic [7:0] e1, input bit drop2);
      q[p].push_back('{{32'b0, e0}, cyc + 1});
      q[2 + p].push_back('{{32'b0, e1}, cyc + 1});
      if (!drop2) q[4 + p].push_back('{{32'b0, e0}, cyc + 2});
   endtask

   task automatic wr(input bit p, input int a, input logic [7:0] d);
      if (p) begin wen_b = 1'b1; addr_b = 12'(a); din_b = d; end
      else begin wen_a = 1'b1; addr_a = 12'(a); din_a = d; end
      step();
      idle();
   endtask

   task automatic rd(input bit p, input int a, input logic [7:0] e0, input logic [7:0] e1);
      if (p) begin ren_b = 1'b1; addr_b = 12'(a); end
      else begin ren_a = 1'b1; addr_a = 12'(a); end
      push8(p, e0, e1, 1'b0);
      step();
      idle();
   endtask

   initial begin
      logic [7:0] t5 [4];
      t5 = '{8'hA0, 8'hA1, 8'hA2, 8'h11};
      idle();
      {addr_a, addr_b, din_a, din_b} = '0;
      {w_addr_a, w_addr_b, w_din_a, w_din_b} = '0;
      repeat (2) step();
      check("reset outputs k0", {21'b0, g_dut[0].outs}, 40'b0);
      check("reset outputs k1", {21'b0, g_dut[1].outs}, 40'b0);
      check("reset outputs k2", {21'b0, g_dut[2].outs}, 40'b0);
      check("reset outputs w40", {38'b0, b40.rd_valid_a, b40.rd_valid_b}, 40'b0);
      rst = 1'b0;
      step();
      // W=40: 4 words per row
      w_wen_a = 1'b1; w_addr_a = 9'd5; w_din_a = 40'h123456789A;
      step();
      idle();
      w_ren_b = 1'b1; w_addr_b = 9'd5;
      q[7].push_back('{40'h123456789A, cyc + 1});
      step();
      idle();
      w_wen_b = 1'b1; w_addr_b = 9'd6; w_din_b = 40'hFEDCBA9876;
      step();
      idle();
      w_ren_a = 1'b1; w_addr_a = 9'd6;
      q[6].push_back('{40'hFEDCBA9876, cyc + 1});
      step();
      w_addr_a = 9'd4;
      q[6].push_back('{40'h0, cyc + 1});
      step();
      idle();
      // W=8 mapping
      wr(0, 21, 8'hC3);
      rd(0, 20, 8'h00, 8'h00);
      rd(0, 21, 8'hC3, 8'hC3);
      rd(1, 21, 8'hC3, 8'hC3);
      // same-address dual write: port A wins and collision pulses
      wen_a = 1'b1; addr_a = 12'd3; din_a = 8'h11;
      wen_b = 1'b1; addr_b = 12'd3; din_b = 8'h22;
      coll_due = cyc + 1;
      step();
      idle();
      rd(1, 3, 8'h11, 8'h11);
      // same-port read-during-write
      wr(0, 7, 8'hAA);
      ren_a = 1'b1; wen_a = 1'b1; addr_a = 12'd7; din_a = 8'h55;
      push8(0, 8'hAA, 8'h55, 1'b0);
      step();
      idle();
      rd(0, 7, 8'h55, 8'h55);
      // cross-port read-during-write returns old data in every mode
      wr(1, 9, 8'h33);
      wen_a = 1'b1; addr_a = 12'd9; din_a = 8'h77;
      ren_b = 1'b1; addr_b = 12'd9;
      push8(1, 8'h33, 8'h33, 1'b0);
      step();
      idle();
      rd(1, 9, 8'h77, 8'h77);
      // different words of one row: both land, no collision
      wen_a = 1'b1; addr_a = 12'd40; din_a = 8'h01;
      wen_b = 1'b1; addr_b = 12'd41; din_b = 8'h02;
      step();
      idle();
      rd(0, 40, 8'h01, 8'h01);
      rd(1, 41, 8'h02, 8'h02);
      // out of range: 3000 would alias row 22 col 0 (addr 440) if not rejected
      wr(0, 3000, 8'hFF);
      rd(0, 3000, 8'h00, 8'h00);
      rd(1, 440, 8'h00, 8'h00);
      // back-to-back reads
      wr(0, 0, 8'hA0);
      wr(0, 1, 8'hA1);
      wr(0, 2, 8'hA2);
      for (int i = 0; i < 4; i++) begin
         ren_a = 1'b1; addr_a = 12'(i);
         push8(0, t5[i], t5[i], 1'b0);
         step();
      end
      idle();
      repeat (3) step();
      // reset one cycle after a read: the registered-output variant must drop it
      ren_a = 1'b1; addr_a = 12'd2;
      push8(0, 8'hA2, 8'hA2, 1'b1);
      step();
      idle();
      rst = 1'b1;
      wen_a = 1'b1; addr_a = 12'd50; din_a = 8'h99;
      repeat (2) step();
      check("mid-op reset k0", {21'b0, g_dut[0].outs}, 40'b0);
      check("mid-op reset k1", {21'b0, g_dut[1].outs}, 40'b0);
      check("mid-op reset k2", {21'b0, g_dut[2].outs}, 40'b0);
      idle();
      rst = 1'b0;
      step();
      rd(0, 50, 8'h00, 8'h00);
      repeat (4) step();
      for (int i = 0; i < 8; i++) check($sformatf("reads outstanding q%0d", i), 40'(q[i].size()), 40'b0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
